deadlock_cycle_tracker: RTL and testbench
=========================================

Name: deadlock_cycle_tracker

Overview:
Parametrised, synthesizable deadlock detector and cycle tracer for dataflow regions of PROC_NUM processes. It filters transient blocked states and injects a one-hot token per unreported cycle origin. It then traces token propagation through dl_in_vec and emits one membership report per dependence cycle over a valid/ready channel. It sits beside the dataflow top level, fed by per-process blocked indicators, and replaces print-only reporting with a hardware-readable report stream.

Parameters:
PROC_NUM, 4, number of monitored processes (>=2)
KEEP_THRESH, 1000, consecutive qualifying FILTER cycles required to declare deadlock (>=1)
TRACE_MAX, 64, max TRACE cycles before a trace is aborted (>=2)
MAX_CYCLES, 8, max reports emitted before forced DONE (1..255)

Ports:
dl_clock  in  1  clock
dl_reset  in  1  reset; asynchronous, active-low
dl_in_vec  in  PROC_NUM  per-process blocked/token-holder indicator
clear  in  1  synchronous re-arm; returns to IDLE
dl_detect_out  out  1  deadlock confirmed (level)
origin  out  PROC_NUM  one-hot token injection, valid one cycle in DETECTED
token_clear  out  1  one-cycle pulse when the token returns to origin
rpt_valid  out  1  report available
rpt_ready  in  1  report consumer ready
rpt_cycle_id  out  8  1-based cycle index
rpt_members  out  PROC_NUM  processes seen in this cycle
rpt_len  out  $clog2(PROC_NUM)+1  popcount(rpt_members)
rpt_aborted  out  1  trace hit TRACE_MAX
dl_all_done  out  1  all cycles reported (level)

Behaviour:
- Reset (dl_reset=0, async): state IDLE. All registers 0. All outputs 0.
- clear=1 in any state: next state IDLE, all registers cleared. clear has priority over every other transition.
- States: IDLE, FILTER, DETECTED, TRACE, EMIT, DONE.
- IDLE: detect_reg <= dl_in_vec every cycle; keep_cnt <= 0. If |dl_in_vec, go to FILTER.
- FILTER: qualify = (detect_reg & dl_in_vec) == detect_reg.
  - If not qualify: go to IDLE, keep_cnt <= 0.
  - Else keep_cnt <= keep_cnt+1. If keep_cnt+1 == KEEP_THRESH, go to DETECTED.
  - Net effect: DETECTED follows exactly KEEP_THRESH consecutive qualifying FILTER cycles.
- DETECTED: pend = detect_reg & ~done_reg.
  - If pend != 0: origin = lowest set bit of pend (combinational, this cycle only); origin_reg <= origin; members <= origin; trace_cnt <= 0; go to TRACE.
  - Else (or if rpt count == MAX_CYCLES): go to DONE.
  - origin = 0 in all other states.
- TRACE, if dl_in_vec & origin_reg != 0: token_clear=1 (same cycle, combinational); done_reg <= done_reg | members; aborted <= 0; go to EMIT.
- TRACE, else if trace_cnt == TRACE_MAX-1: done_reg <= done_reg | members | origin_reg; aborted <= 1; go to EMIT. This guarantees forward progress.
- TRACE, else: members <= members | dl_in_vec; trace_cnt++.
- EMIT: rpt_valid=1. rpt_* are registered and held stable until rpt_ready.
  - On rpt_valid & rpt_ready: cycle_id++ and go to DETECTED.
  - rpt_ready while not in EMIT is ignored.
- DONE: dl_all_done=1; stay until clear.
- dl_detect_out = |detect_reg && state in {DETECTED, TRACE, EMIT, DONE}.
- rpt_cycle_id starts at 1 and never exceeds MAX_CYCLES. rpt_len is computed from the registered members.
- dl_in_vec changing after DETECTED does not reset detection; only clear or dl_reset re-arms.

Optional Feature:
DEADLOCK_SIM_PRINT_EN
- Defined: at each report handshake, $display prints cycle id, member indices, length and the aborted flag. On entry to DONE, prints "Totally N cycles detected". Simulation only.
- Undefined: no system tasks or functions compiled; the block is fully synthesizable. Port behaviour is identical either way.

Test Plan:
(Bench uses PROC_NUM=4, KEEP_THRESH=8, TRACE_MAX=16, MAX_CYCLES=8.)
- Fake filter: dl_in_vec=4'b0011 for 5 cycles, then 4'b0001 -> return to IDLE; dl_detect_out stays 0; keep_cnt back to 0.
- Single cycle: hold 4'b0011 for 8 FILTER cycles -> DETECTED, origin=4'b0001 for 1 cycle. Drive 4'b0010, then 4'b0001 -> token_clear pulse; report id=1, members=4'b0011, len=2, aborted=0. Then dl_all_done=1.
- Two cycles: detect_reg=4'b1111 with cycles {0,1} and {2,3}. Second origin=4'b0100. Reports id=1 members=0011 and id=2 members=1100, then DONE.
- Backpressure: hold rpt_ready=0 for 10 cycles in EMIT -> rpt_valid stays 1, data stable; one handshake only when rpt_ready=1.
- Abort: token never returns in TRACE -> after 16 cycles report aborted=1, origin bit marked done, FSM proceeds.
- Async reset mid-TRACE and clear in DONE -> all outputs 0 immediately (reset) or next cycle (clear); a new detection works afterwards.

Source files
------------

// File: rtl/deadlock_cycle_tracker.sv
// Deadlock detector and dependence-cycle tracer for a dataflow region of PROC_NUM processes.
// Optional simulation-only report printing is enabled with `define DEADLOCK_SIM_PRINT_EN.
module deadlock_cycle_tracker #(
  parameter int PROC_NUM    = 4,
  parameter int KEEP_THRESH = 1000,
  parameter int TRACE_MAX   = 64,
  parameter int MAX_CYCLES  = 8
) (
  input  logic                      dl_clock,
  input  logic                      dl_reset,
  input  logic [PROC_NUM-1:0]       dl_in_vec,
  input  logic                      clear,
  output logic                      dl_detect_out,
  output logic [PROC_NUM-1:0]       origin,
  output logic                      token_clear,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [7:0]                rpt_cycle_id,
  output logic [PROC_NUM-1:0]       rpt_members,
  output logic [$clog2(PROC_NUM):0] rpt_len,
  output logic                      rpt_aborted,
  output logic                      dl_all_done
);

  localparam int LW = $clog2(PROC_NUM) + 1;
  localparam int KW = $clog2(KEEP_THRESH + 1);
  localparam int TW = $clog2(TRACE_MAX);
  localparam logic [KW-1:0] KEEP_LAST  = KW'(KEEP_THRESH - 1);
  localparam logic [KW-1:0] KEEP_ONE   = KW'(1);
  localparam logic [TW-1:0] TRACE_LAST = TW'(TRACE_MAX - 1);
  localparam logic [TW-1:0] TRACE_ONE  = TW'(1);
  localparam logic [7:0]    RPT_LIMIT  = 8'(MAX_CYCLES);
  localparam logic [PROC_NUM-1:0] VEC_ONE = PROC_NUM'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILTER   = 3'd1,
    DETECTED = 3'd2,
    TRACE    = 3'd3,
    EMIT     = 3'd4,
    DONE     = 3'd5
  } state_t;

  function automatic logic [LW-1:0] popcnt(input logic [PROC_NUM-1:0] v);
    logic [LW-1:0] acc;
    acc = '0;
    for (int i = 0; i < PROC_NUM; i++) begin
      acc = acc + LW'(v[i]);
    end
    return acc;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PROC_NUM-1:0] r_detect;
  logic [PROC_NUM-1:0] r_done;
  logic [PROC_NUM-1:0] r_origin;
  logic [PROC_NUM-1:0] r_members;
  logic [KW-1:0]       r_keep_cnt;
  logic [TW-1:0]       r_trace_cnt;
  logic [7:0]          r_rpt_cnt;
  logic [7:0]          r_rpt_id;
  logic                r_aborted;

  logic [PROC_NUM-1:0] w_pend;
  logic [PROC_NUM-1:0] w_lowest;
  logic [PROC_NUM-1:0] w_origin;
  logic                w_qualify;
  logic                w_keep_last;
  logic                w_can_trace;
  logic                w_returned;
  logic                w_trace_last;
  logic                w_token_clear;

  assign w_pend       = r_detect & ~r_done;
  // Two's-complement trick isolates the lowest pending process as the next origin.
  assign w_lowest     = w_pend & (~w_pend + VEC_ONE);
  assign w_qualify    = ((r_detect & dl_in_vec) == r_detect);
  assign w_keep_last  = (r_keep_cnt == KEEP_LAST);
  assign w_can_trace  = (|w_pend) && (r_rpt_cnt < RPT_LIMIT);
  assign w_returned   = |(dl_in_vec & r_origin);
  assign w_trace_last = (r_trace_cnt == TRACE_LAST);

  // Next-state selection plus the combinational origin and token_clear strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_origin      = '0;
    w_token_clear = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (|dl_in_vec) w_state_nxt = FILTER;
          else            w_state_nxt = IDLE;
        end
        FILTER: begin
          if (!w_qualify)       w_state_nxt = IDLE;
          else if (w_keep_last) w_state_nxt = DETECTED;
          else                  w_state_nxt = FILTER;
        end
        DETECTED: begin
          if (w_can_trace) begin
            w_origin    = w_lowest;
            w_state_nxt = TRACE;
          end else begin
            w_state_nxt = DONE;
          end
        end
        TRACE: begin
          if (w_returned) begin
            w_token_clear = 1'b1;
            w_state_nxt   = EMIT;
          end else if (w_trace_last) begin
            w_state_nxt = EMIT;
          end else begin
            w_state_nxt = TRACE;
          end
        end
        EMIT: begin
          if (rpt_ready) w_state_nxt = DETECTED;
          else           w_state_nxt = EMIT;
        end
        DONE:    w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register and per-state datapath updates; clear re-arms everything.
  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      r_state     <= IDLE;
      r_detect    <= '0;
      r_done      <= '0;
      r_origin    <= '0;
      r_members   <= '0;
      r_keep_cnt  <= '0;
      r_trace_cnt <= '0;
      r_rpt_cnt   <= 8'd0;
      r_rpt_id    <= 8'd0;
      r_aborted   <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_detect    <= '0;
      r_done      <= '0;
      r_origin    <= '0;
      r_members   <= '0;
      r_keep_cnt  <= '0;
      r_trace_cnt <= '0;
      r_rpt_cnt   <= 8'd0;
      r_rpt_id    <= 8'd0;
      r_aborted   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          r_detect   <= dl_in_vec;
          r_keep_cnt <= '0;
        end
        FILTER: begin
          if (!w_qualify) r_keep_cnt <= '0;
          else            r_keep_cnt <= r_keep_cnt + KEEP_ONE;
        end
        DETECTED: begin
          if (w_can_trace) begin
            r_origin    <= w_lowest;
            r_members   <= w_lowest;
            r_trace_cnt <= '0;
          end
        end
        TRACE: begin
          if (w_returned) begin
            r_done    <= r_done | r_members;
            r_aborted <= 1'b0;
            r_rpt_id  <= r_rpt_cnt + 8'd1;
          end else if (w_trace_last) begin
            // Marking the origin done guarantees the next pass picks a new origin.
            r_done    <= r_done | r_members | r_origin;
            r_aborted <= 1'b1;
            r_rpt_id  <= r_rpt_cnt + 8'd1;
          end else begin
            r_members   <= r_members | dl_in_vec;
            r_trace_cnt <= r_trace_cnt + TRACE_ONE;
          end
        end
        EMIT: begin
          if (rpt_ready) r_rpt_cnt <= r_rpt_cnt + 8'd1;
        end
        default: begin
          r_rpt_cnt <= r_rpt_cnt;
        end
      endcase
    end
  end

  assign origin        = w_origin;
  assign token_clear   = w_token_clear;
  assign dl_detect_out = (|r_detect) && ((r_state == DETECTED) || (r_state == TRACE) ||
                                         (r_state == EMIT) || (r_state == DONE));
  assign rpt_valid     = (r_state == EMIT);
  assign dl_all_done   = (r_state == DONE);
  assign rpt_cycle_id  = r_rpt_id;
  assign rpt_members   = r_members;
  assign rpt_len       = popcnt(r_members);
  assign rpt_aborted   = r_aborted;

`ifdef DEADLOCK_SIM_PRINT_EN
  // Human-readable trace of each handshaken report and of the final total.
  always @(posedge dl_clock) begin
    if (dl_reset && !clear) begin
      if (r_state == EMIT && rpt_ready) begin
        $write("deadlock cycle %0d members:", r_rpt_id);
        for (int i = 0; i < PROC_NUM; i++) begin
          if (r_members[i]) $write(" %0d", i);
        end
        $display(" len %0d aborted %0d", rpt_len, r_aborted);
      end
      if (r_state != DONE && w_state_nxt == DONE) begin
        $display("Totally %0d cycles detected", r_rpt_cnt);
      end
    end
  end
`else
  // Synthesis build: reports are observable only through the rpt_* channel.
`endif

endmodule

// File: tb/tb_deadlock_cycle_tracker.sv
// Scoreboard bench for deadlock_cycle_tracker: filter, single/dual cycles, backpressure, abort, reset/clear.
module tb_deadlock_cycle_tracker;

  localparam int PN = 4;
  localparam int KT = 8;
  localparam int TM = 16;
  localparam int MC = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PN-1:0] in_vec;
  logic          clr;
  logic          detect_out;
  logic [PN-1:0] origin;
  logic          token_clear;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [7:0]    rpt_cycle_id;
  logic [PN-1:0] rpt_members;
  logic [2:0]    rpt_len;
  logic          rpt_aborted;
  logic          all_done;

  typedef struct packed {
    logic [7:0]    id;
    logic [PN-1:0] mem;
    logic [2:0]    len;
    logic          ab;
  } rpt_t;

  rpt_t exp_q[$];
  rpt_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  deadlock_cycle_tracker #(
    .PROC_NUM(PN), .KEEP_THRESH(KT), .TRACE_MAX(TM), .MAX_CYCLES(MC)
  ) dut (
    .dl_clock(clk), .dl_reset(rst_n), .dl_in_vec(in_vec), .clear(clr),
    .dl_detect_out(detect_out), .origin(origin), .token_clear(token_clear),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_cycle_id(rpt_cycle_id),
    .rpt_members(rpt_members), .rpt_len(rpt_len), .rpt_aborted(rpt_aborted),
    .dl_all_done(all_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] id, input logic [PN-1:0] mem, input logic [2:0] len,
                      input logic ab);
    rpt_t e;
    e.id = id; e.mem = mem; e.len = len; e.ab = ab;
    exp_q.push_back(e);
  endtask

  task automatic outputs_zero(input string tag);
    check_eq({tag, "_det"}, {31'd0, detect_out}, 32'd0);
    check_eq({tag, "_vld"}, {31'd0, rpt_valid}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, all_done}, 32'd0);
    check_eq({tag, "_org"}, {28'd0, origin}, 32'd0);
    check_eq({tag, "_tclr"}, {31'd0, token_clear}, 32'd0);
    check_eq({tag, "_id"}, {24'd0, rpt_cycle_id}, 32'd0);
    check_eq({tag, "_mem"}, {28'd0, rpt_members}, 32'd0);
  endtask

  // From IDLE: hold pat for one IDLE edge plus KT qualifying FILTER edges.
  task automatic detect(input logic [PN-1:0] pat);
    in_vec = pat;
    cyc(1);
    cyc(KT - 1);
    check_eq("det_before_thresh", {31'd0, detect_out}, 32'd0);
    cyc(1);
    check_eq("det_at_thresh", {31'd0, detect_out}, 32'd1);
  endtask

  // In TRACE: one intermediate hop, then the token lands back home.
  task automatic ring(input logic [PN-1:0] hop, input logic [PN-1:0] home);
    in_vec = hop;
    cyc(1);
    check_eq("origin_one_shot", {28'd0, origin}, 32'd0);
    cyc(1);
    check_eq("tclr_idle", {31'd0, token_clear}, 32'd0);
    in_vec = home;
    #1;
    check_eq("tclr_pulse", {31'd0, token_clear}, 32'd1);
    cyc(1);
    check_eq("tclr_gone", {31'd0, token_clear}, 32'd0);
  endtask

  // Scoreboard monitor: compare each handshaken report with the oldest expectation.
  always @(negedge clk) begin
    if (rpt_valid && rpt_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("rpt_id", {24'd0, rpt_cycle_id}, {24'd0, mon_e.id});
        check_eq("rpt_members", {28'd0, rpt_members}, {28'd0, mon_e.mem});
        check_eq("rpt_len", {29'd0, rpt_len}, {29'd0, mon_e.len});
        check_eq("rpt_aborted", {31'd0, rpt_aborted}, {31'd0, mon_e.ab});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_vec = '0; clr = 1'b0; rpt_ready = 1'b1;
    #1;
    outputs_zero("reset");
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Fake filter: 0011 for 5 edges, then 0001 breaks qualification.
    in_vec = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check_eq("fake_det", {31'd0, detect_out}, 32'd0);
    end
    in_vec = 4'b0001;
    cyc(1);
    in_vec = 4'b0000;
    cyc(1);
    check_eq("fake_det_idle", {31'd0, detect_out}, 32'd0);

    // Single cycle {0,1}.
    push(8'd1, 4'b0011, 3'd2, 1'b0);
    detect(4'b0011);
    check_eq("single_origin", {28'd0, origin}, 32'h1);
    ring(4'b0010, 4'b0001);
    check_eq("single_valid", {31'd0, rpt_valid}, 32'd1);
    cyc(1);
    check_eq("single_notdone", {31'd0, all_done}, 32'd0);
    cyc(1);
    check_eq("single_done", {31'd0, all_done}, 32'd1);
    check_eq("single_det_done", {31'd0, detect_out}, 32'd1);
    clr = 1'b1;
    in_vec = '0;
    cyc(1);
    clr = 1'b0;
    outputs_zero("clear");

    // Two cycles {0,1} and {2,3} with backpressure on the first report.
    push(8'd1, 4'b0011, 3'd2, 1'b0);
    push(8'd2, 4'b1100, 3'd2, 1'b0);
    rpt_ready = 1'b0;
    detect(4'b1111);
    check_eq("two_origin1", {28'd0, origin}, 32'h1);
    ring(4'b0010, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", {31'd0, rpt_valid}, 32'd1);
      check_eq("bp_members", {28'd0, rpt_members}, 32'h3);
      check_eq("bp_id", {24'd0, rpt_cycle_id}, 32'd1);
      cyc(1);
    end
    check_eq("bp_no_pop", exp_q.size(), 32'd2);
    rpt_ready = 1'b1;
    cyc(1);
    check_eq("bp_one_pop", exp_q.size(), 32'd1);
    check_eq("two_origin2", {28'd0, origin}, 32'h4);
    ring(4'b1000, 4'b0100);
    cyc(2);
    check_eq("two_done", {31'd0, all_done}, 32'd1);
    check_eq("two_sb_empty", exp_q.size(), 32'd0);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check_eq("clear2_done", {31'd0, all_done}, 32'd0);

    // Abort: token never returns; origin 0 is retired and origin 1 is chosen next.
    push(8'd1, 4'b0001, 3'd1, 1'b1);
    detect(4'b0011);
    check_eq("abort_origin1", {28'd0, origin}, 32'h1);
    in_vec = 4'b0000;
    cyc(1);
    cyc(TM - 1);
    check_eq("abort_still_trace", {31'd0, rpt_valid}, 32'd0);
    cyc(1);
    check_eq("abort_valid", {31'd0, rpt_valid}, 32'd1);
    check_eq("abort_flag", {31'd0, rpt_aborted}, 32'd1);
    cyc(1);
    check_eq("abort_next_origin", {28'd0, origin}, 32'h2);
    cyc(4);

    // Asynchronous reset mid-TRACE clears outputs without a clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    outputs_zero("async_rst");
    check_eq("abort_sb_empty", exp_q.size(), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check_eq("post_rst_det", {31'd0, detect_out}, 32'd0);

    // Fresh detection after reset.
    push(8'd1, 4'b0011, 3'd2, 1'b0);
    detect(4'b0011);
    check_eq("rearm_origin", {28'd0, origin}, 32'h1);
    ring(4'b0010, 4'b0001);
    cyc(2);
    check_eq("rearm_done", {31'd0, all_done}, 32'd1);
    check_eq("final_sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
